sub32_serial: RTL and testbench
===============================

# sub32_serial

Sequential sign-magnitude subtractor, the inverse-operation companion to the team's combinational sign-magnitude adder. Accepts two WIDTH-bit sign-magnitude operands plus a borrow-in on a start pulse. Computes x − y − borrowin bit-serially over WIDTH+1 cycles and returns a sign-magnitude difference with negative and overflow flags. Sits in the arithmetic unit of the lab datapath, where area matters more than latency.

## Interface
- WIDTH, 32, operand/result width in bits; bit WIDTH-1 is sign, bits WIDTH-2:0 are magnitude.
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only when idle.
- borrowin  in  1  borrow-in; subtracted from the result.
- x  in  WIDTH  minuend, sign-magnitude.
- y  in  WIDTH  subtrahend, sign-magnitude.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when d/isneg/isover become valid.
- d  out  WIDTH  difference, sign-magnitude.
- isneg  out  1  equals d[WIDTH-1].
- isover  out  1  true result not representable in WIDTH-bit sign-magnitude.

## Operation
- States: IDLE, SHIFT, FIX.
- **IDLE**:
  - On start, latch borrowin.
  - Convert x and y to (WIDTH+1)-bit two's complement and latch them.
  - Conversion: sign 0 → zero-extend; sign 1 → negate the magnitude.
  - −0 (sign 1, magnitude 0) converts to 0.
  - Clear the bit counter, go to SHIFT.
- **SHIFT**:
  - Each cycle, process LSB-first one bit of a (from x) and b (from y), with running borrow br (initialised to borrowin).
  - diff = a^b^br.
  - br_next = (~a&b) | (~a&br) | (b&br).
  - Shift diff into the result register MSB-first-filled.
  - Exactly WIDTH+1 cycles, then go to FIX.
- **FIX** (one cycle): R is the (WIDTH+1)-bit two's-complement result.
  - sign = R[WIDTH].
  - mag = |R|.
  - isover = (mag > 2^(WIDTH-1) − 1).
  - d = {sign, mag[WIDTH-2:0]}; truncated on overflow, sign still the true sign.
  - If R == 0, d = 0 and isneg = 0; −0 is never produced.
  - Register d/isneg/isover, pulse done, go to IDLE.
- Final borrow-out is discarded; the WIDTH+1 extension makes it redundant.
- start while busy: ignored, no queueing.
- start while done is high: state is IDLE, so it is accepted. Back-to-back operations are supported.
- d/isneg/isover hold their values until the next FIX.
- Inputs x/y/borrowin are don't-care after the start cycle.

## Timing
- Reset values:
  - state IDLE, busy 0, done 0.
  - d 0, isneg 0, isover 0.
  - Counter 0, operand registers 0.
- Reset mid-operation aborts immediately; no done is produced.
- start sampled high at edge k:
  - busy = 1 from after edge k.
  - SHIFT occupies edges k+1 … k+WIDTH+1.
  - FIX at edge k+WIDTH+2 → done = 1 and outputs valid for the following cycle; busy = 0 in the same cycle.
- Latency: WIDTH+2 cycles from start edge to done (34 for WIDTH=32).
- Next start is accepted at the edge where done is high.
- done is high for exactly one cycle per accepted start.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `arith_pkg`:
  - state enum {IDLE, SHIFT, FIX}.
  - Default WIDTH constant.
  - Counter-width function (clog2(WIDTH+2)).
- Sub-module `sm2tc`: combinational sign-magnitude → (WIDTH+1)-bit two's-complement converter, parameterised on WIDTH. Instantiated twice (x, y).
- Result conversion back to sign-magnitude is inline in FIX.

## Test plan
- x=0x00000005, y=0x00000003, borrowin=0 → d=0x00000002, isneg=0, isover=0; done exactly 34 cycles after start.
- x=0x00000003, y=0x00000005 → d=0x80000002, isneg=1. Also x=0x80000004, y=0x00000006, borrowin=1 → d=0x8000000B.
- Overflow:
  - x=0x7FFFFFFF, y=0x80000001 → d=0x00000000, isover=1.
  - x=0xFFFFFFFF, y=0x00000001, borrowin=1 → d=0x80000001, isover=1, isneg=1.
- Zero handling:
  - x=0x80000000, y=0x80000000 → d=0x00000000, isneg=0.
  - x=0x00000007, y=0x00000007 → d=0, isneg=0.
- Handshake: start pulsed again at cycles 5 and 20 of a busy operation → ignored, single done. Start asserted on the done cycle → second result 34 cycles later.
- rst asserted at SHIFT cycle 10:
  - next cycle: busy=0, all outputs 0.
  - no done pulse.
  - a fresh start completes normally.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the serial sign-magnitude arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIX
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // Bit counter must reach WIDTH (WIDTH+1 serial steps) without wrapping.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/sm2tc.sv
// Sign-magnitude to (WIDTH+1)-bit two's-complement converter; -0 maps to 0.
module sm2tc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] sm,
    output logic [WIDTH:0]   tc
);

    logic [WIDTH:0] mag;

    always_comb begin
        mag = {2'b00, sm[WIDTH-2:0]};
        tc  = sm[WIDTH-1] ? -mag : mag;
    end

endmodule

// File: rtl/sub32_serial.sv
// Bit-serial sign-magnitude subtractor: d = x - y - borrowin over WIDTH+1 shift cycles.
module sub32_serial
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             borrowin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             isneg,
    output logic             isover
);

    localparam int unsigned   CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic [WIDTH:0] a, b, r;
    logic [WIDTH:0] x_tc, y_tc, mag;
    logic           br, diff, br_next;
    logic [WIDTH-1:0] fix_d;
    logic           fix_neg, fix_over;

    sm2tc #(.WIDTH(WIDTH)) u_x_conv (.sm(x), .tc(x_tc));
    sm2tc #(.WIDTH(WIDTH)) u_y_conv (.sm(y), .tc(y_tc));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_comb begin
        diff    = a[0] ^ b[0] ^ br;
        br_next = (~a[0] & b[0]) | (~a[0] & br) | (b[0] & br);
        mag     = r[WIDTH] ? -r : r;
        // Zero result forces a positive zero so -0 never leaves the block.
        fix_neg  = (r != '0) && r[WIDTH];
        fix_over = |mag[WIDTH:WIDTH-1];
        fix_d    = (r == '0) ? '0 : {r[WIDTH], mag[WIDTH-2:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a      <= '0;
            b      <= '0;
            r      <= '0;
            br     <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            isneg  <= 1'b0;
            isover <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a   <= x_tc;
                        b   <= y_tc;
                        br  <= borrowin;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    a   <= a >> 1;
                    b   <= b >> 1;
                    br  <= br_next;
                    r   <= {diff, r[WIDTH:1]};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    d      <= fix_d;
                    isneg  <= fix_neg;
                    isover <= fix_over;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub32_serial.sv
// Directed and random checks of sub32_serial against an integer-arithmetic reference.
module tb_sub32_serial;

    logic        clk = 1'b0;
    logic        rst, start, borrowin;
    logic [31:0] x, y;
    logic        busy, done, isneg, isover;
    logic [31:0] d;

    int checks = 0;
    int errors = 0;

    sub32_serial #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .borrowin(borrowin),
        .x(x), .y(y), .busy(busy), .done(done),
        .d(d), .isneg(isneg), .isover(isover)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {isover, isneg, d} from signed integer arithmetic.
    function automatic logic [33:0] model(input logic [31:0] xx, input logic [31:0] yy,
                                          input logic bi);
        longint      xv, yv, rv, mv;
        logic [63:0] mu;
        logic [31:0] dd;
        xv = longint'({33'b0, xx[30:0]});
        yv = longint'({33'b0, yy[30:0]});
        if (xx[31]) xv = -xv;
        if (yy[31]) yv = -yv;
        rv = xv - yv - longint'(bi);
        mv = (rv < 0) ? -rv : rv;
        mu = mv;
        dd = (rv == 0) ? 32'h0 : {(rv < 0), mu[30:0]};
        return {(mv > 64'h7FFF_FFFF), dd[31], dd};
    endfunction

    // Called just after a clock edge; start is sampled at the next edge.
    task automatic launch(input logic [31:0] xx, input logic [31:0] yy, input logic bi);
        x = xx; y = yy; borrowin = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x = $urandom; y = $urandom; borrowin = 1'($urandom);
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
            if (done) return;
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] xx,
                                input logic [31:0] yy, input logic bi);
        logic [33:0] e;
        e = model(xx, yy, bi);
        check({tag, "_d"}, 64'(d), 64'(e[31:0]));
        check({tag, "_isneg"}, 64'(isneg), 64'(e[32]));
        check({tag, "_isover"}, 64'(isover), 64'(e[33]));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] xx,
                          input logic [31:0] yy, input logic bi);
        int cyc;
        launch(xx, yy, bi);
        wait_done(cyc);
        check({tag, "_latency"}, 64'(cyc), 64'd34);
        check_result(tag, xx, yy, bi);
    endtask

    initial begin
        int cyc, ndone, done_at;
        logic [31:0] rx, ry;
        logic        rb;

        rst = 1'b1; start = 1'b0; borrowin = 1'b0; x = '0; y = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_outs", 64'({d, isneg, isover}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("pos_small", 32'h0000_0005, 32'h0000_0003, 1'b0);
        check("pos_small_const", 64'(d), 64'h2);
        run_op("neg_small", 32'h0000_0003, 32'h0000_0005, 1'b0);
        check("neg_small_const", 64'(d), 64'h8000_0002);
        run_op("neg_borrow", 32'h8000_0004, 32'h0000_0006, 1'b1);
        check("neg_borrow_const", 64'(d), 64'h8000_000B);
        run_op("ovf_pos", 32'h7FFF_FFFF, 32'h8000_0001, 1'b0);
        check("ovf_pos_const", 64'({isover, d}), {31'b0, 1'b1, 32'h0});
        run_op("ovf_neg", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        check("ovf_neg_const", 64'({isover, isneg, d}), {30'b0, 2'b11, 32'h8000_0001});
        run_op("negzero", 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("equal", 32'h0000_0007, 32'h0000_0007, 1'b0);
        check("equal_const", 64'({isneg, d}), 64'h0);

        // Start pulses during a busy operation must be ignored.
        x = 32'h0000_1234; y = 32'h8000_0020; borrowin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; done_at = 0;
        for (int c = 1; c <= 80; c++) begin
            start = (c == 4 || c == 19);
            x = 32'h0000_0001; y = 32'h0000_0009;
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (done_at == 0) begin
                    done_at = c;
                    check_result("ignore_busy", 32'h0000_1234, 32'h8000_0020, 1'b0);
                end
            end
        end
        start = 1'b0;
        check("ignore_busy_ndone", 64'(ndone), 64'd1);
        check("ignore_busy_latency", 64'(done_at), 64'd34);

        // Back-to-back: second start issued in the done cycle.
        launch(32'h0000_0100, 32'h0000_0001, 1'b0);
        wait_done(cyc);
        check("b2b_first_latency", 64'(cyc), 64'd34);
        check_result("b2b_first", 32'h0000_0100, 32'h0000_0001, 1'b0);
        launch(32'h8000_0010, 32'h8000_0030, 1'b1);
        wait_done(cyc);
        check("b2b_second_latency", 64'(cyc), 64'd34);
        check_result("b2b_second", 32'h8000_0010, 32'h8000_0030, 1'b1);

        // Reset in the middle of SHIFT aborts without a done pulse.
        launch(32'h0000_0050, 32'h0000_0010, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_outs", 64'({d, isneg, isover}), 64'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midrst_no_done", 64'(ndone), 64'd0);
        run_op("after_rst", 32'h0000_0050, 32'h0000_0010, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rx = $urandom; ry = $urandom; rb = 1'($urandom);
            if (i % 4 == 1) rx[30:4] = '1;
            if (i % 4 == 2) ry = rx;
            run_op("random", rx, ry, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
